// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// word geometry and the modulo-256 checksum helper.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] WORD_EN_ALL    = 4'hF;

  function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs accepted stream bytes little-endian into a 32-bit word and keeps
// the running modulo-256 byte sum used for the trailing checksum.
module word_assembler
  import loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_accept,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full,
  output logic [7:0]  o_sum
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;
  logic [7:0]  r_sum;

  function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                              input logic [1:0]  idx,
                                              input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      2'd3:    res[31:24] = b;
      default: res = word;
    endcase
    return res;
  endfunction

  // Byte index wraps 3->0 on its own, so a finished word needs no explicit restart.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_byte_idx <= 2'd0;
      r_word     <= 32'd0;
      r_sum      <= 8'd0;
    end else if (i_clear) begin
      r_byte_idx <= 2'd0;
      r_word     <= 32'd0;
      r_sum      <= 8'd0;
    end else if (i_accept) begin
      r_byte_idx <= r_byte_idx + 2'd1;
      r_word     <= insert_byte(r_word, r_byte_idx, i_byte);
      r_sum      <= sum8(r_sum, i_byte);
    end else begin
      r_byte_idx <= r_byte_idx;
      r_word     <= r_word;
      r_sum      <= r_sum;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = i_accept && (r_byte_idx == LAST_BYTE);
  assign o_sum       = r_sum;

endmodule

// File: rtl/program_loader.sv
// Fills program memory from a ready/valid byte stream, verifies a trailing
// two's-complement checksum and only then releases the CPU core from reset.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-2:0] num_words,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [31:0]           mem_wr_data,
  output logic [3:0]            mem_byte_w_en,
  output logic                  cpu_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH-2:0] CAPACITY = {1'b1, {(ADDR_WIDTH-2){1'b0}}};
  localparam logic [ADDR_WIDTH-2:0] IDX_ONE  = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-2:0] IDX_ZERO = {(ADDR_WIDTH-1){1'b0}};

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-2:0] r_num_words;
  logic [ADDR_WIDTH-2:0] r_word_idx;
  logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
  logic [31:0]           r_mem_wr_data;

  logic                  w_len_ok;
  logic                  w_start_ok;
  logic                  w_accept;
  logic                  w_word_full;
  logic                  w_enter_write;
  logic [31:0]           w_word;
  logic [7:0]            w_sum;
  logic [ADDR_WIDTH-2:0] w_idx_inc;

  word_assembler u_asm (
    .i_clk       (sysclk),
    .i_rst       (rst),
    .i_accept    (w_accept),
    .i_clear     (w_start_ok),
    .i_byte      (byte_in),
    .o_word      (w_word),
    .o_word_full (w_word_full),
    .o_sum       (w_sum)
  );

  assign w_len_ok      = (num_words != IDX_ZERO) && (num_words <= CAPACITY);
  assign w_accept      = (r_state == ST_RECV) && byte_valid;
  assign w_enter_write = (r_state == ST_RECV) && w_word_full;
  assign w_idx_inc     = r_word_idx + IDX_ONE;

  // State register.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; start is honoured only outside a load.
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          if (w_len_ok) begin
            w_state_next = ST_RECV;
            w_start_ok   = 1'b1;
          end else begin
            w_state_next = ST_ERROR;
          end
        end else begin
          w_state_next = r_state;
        end
      end
      ST_RECV: begin
        if (w_word_full) begin
          w_state_next = ST_WRITE;
        end else begin
          w_state_next = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (w_idx_inc == r_num_words) begin
          w_state_next = ST_CHECK;
        end else begin
          w_state_next = ST_RECV;
        end
      end
      ST_CHECK: begin
        if (byte_valid) begin
          if (sum8(w_sum, byte_in) == 8'd0) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_ERROR;
          end
        end else begin
          w_state_next = ST_CHECK;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Word index and memory-port registers; the port captures the word, including
  // its final byte, on the edge that enters WRITE so it is stable through WRITE.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      r_num_words   <= IDX_ZERO;
      r_word_idx    <= IDX_ZERO;
      r_mem_wr_addr <= {ADDR_WIDTH{1'b0}};
      r_mem_wr_data <= 32'd0;
    end else begin
      if (w_start_ok) begin
        r_num_words <= num_words;
        r_word_idx  <= IDX_ZERO;
      end else if (r_state == ST_WRITE) begin
        r_num_words <= r_num_words;
        r_word_idx  <= w_idx_inc;
      end else begin
        r_num_words <= r_num_words;
        r_word_idx  <= r_word_idx;
      end
      if (w_enter_write) begin
        r_mem_wr_addr <= {r_word_idx[ADDR_WIDTH-3:0], 2'b00};
        r_mem_wr_data <= {byte_in, w_word[23:0]};
      end else begin
        r_mem_wr_addr <= r_mem_wr_addr;
        r_mem_wr_data <= r_mem_wr_data;
      end
    end
  end

  assign byte_ready    = (r_state == ST_RECV) || (r_state == ST_CHECK);
  assign mem_byte_w_en = (r_state == ST_WRITE) ? WORD_EN_ALL : 4'h0;
  assign mem_wr_addr   = r_mem_wr_addr;
  assign mem_wr_data   = r_mem_wr_data;
  assign cpu_rst       = (r_state != ST_DONE);
  assign busy          = (r_state == ST_RECV) || (r_state == ST_WRITE) || (r_state == ST_CHECK);
  assign done          = (r_state == ST_DONE);
  assign error         = (r_state == ST_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued as
// bytes are driven and popped by a write monitor on the falling edge.
module tb_program_loader;

  localparam int AW = 12;

  logic          sysclk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-2:0] num_words;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [31:0]   mem_wr_data;
  logic [3:0]    mem_byte_w_en;
  logic          cpu_rst, busy, done, error;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          wr_count = 0;
  int          cyc      = 0;
  int          c0, base;
  bit          rst_done = 1'b0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] words[0:1023];

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  program_loader #(.ADDR_WIDTH(AW)) dut (
    .sysclk(sysclk), .rst(rst), .start(start), .num_words(num_words),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_byte_w_en(mem_byte_w_en), .cpu_rst(cpu_rst), .busy(busy),
    .done(done), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Write monitor: every enabled cycle must match the head of the scoreboard.
  always @(negedge sysclk) begin
    if (rst_done && mem_byte_w_en !== 4'h0) begin
      wr_count++;
      check("wr_en", {28'd0, mem_byte_w_en}, 32'h0000000F);
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", exp_addr_q.size(), 32'd1);
      end else begin
        check("wr_addr", {20'd0, mem_wr_addr}, exp_addr_q.pop_front());
        check("wr_data", mem_wr_data, exp_data_q.pop_front());
      end
      last_addr = {20'd0, mem_wr_addr};
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    bit sent = 1'b0;
    int n = 0;
    while (!sent && n < 64) begin
      @(negedge sysclk);
      n++;
      if (stall && $urandom_range(0, 1) == 0) begin
        byte_valid = 1'b0;
        byte_in    = 8'($urandom);
      end else begin
        byte_in    = b;
        byte_valid = 1'b1;
        sent       = byte_ready;
      end
    end
    check("byte_accept", {31'd0, sent}, 32'd1);
    if (sent) begin
      @(posedge sysclk);
      #1;
      byte_valid = 1'b0;
    end
  endtask

  task automatic do_start(input int n);
    @(negedge sysclk);
    start     = 1'b1;
    num_words = n[AW-2:0];
    @(posedge sysclk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input bit stall, input bit bad);
    logic [7:0] s;
    logic [7:0] ck;
    s = 8'd0;
    for (int i = 0; i < n; i++) begin
      exp_addr_q.push_back(i * 4);
      exp_data_q.push_back(words[i]);
      for (int k = 0; k < 4; k++) begin
        s = s + words[i][8*k +: 8];
        send_byte(words[i][8*k +: 8], stall);
      end
    end
    ck = 8'd0 - s;
    if (bad) ck = ck + 8'd1;
    send_byte(ck, stall);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; byte_in = 8'd0; byte_valid = 1'b0;
    @(posedge sysclk);
    #1 rst_done = 1'b1;
    repeat (2) @(posedge sysclk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge sysclk);
    check("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("rst_flags", {28'd0, busy, done, error, byte_ready}, 32'd0);
    check("rst_w_en", {28'd0, mem_byte_w_en}, 32'd0);

    // Nominal 2-word load at full rate
    words[0] = 32'h00000013;
    words[1] = 32'h00100093;
    base = wr_count;
    do_start(2);
    c0 = cyc;
    check("nom_busy", {31'd0, busy}, 32'd1);
    run_load(2, 1'b0, 1'b0);
    check("nom_load_cycles", cyc - c0, 32'd11);
    check("nom_done", {31'd0, done}, 32'd1);
    check("nom_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("nom_writes", wr_count - base, 32'd2);

    // Reload from DONE, with a start pulse ignored mid-RECV
    do_start(1);
    check("reload_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("reload_done_low", {31'd0, done}, 32'd0);
    exp_addr_q.push_back(32'd0);
    exp_data_q.push_back(32'h11223344);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    do_start(0);
    @(negedge sysclk);
    check("midstart_busy", {31'd0, busy}, 32'd1);
    check("midstart_error", {31'd0, error}, 32'd0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h56, 1'b0);
    check("reload_done", {31'd0, done}, 32'd1);
    check("reload_cpu_rst_low", {31'd0, cpu_rst}, 32'd0);

    // Bad checksum
    base = wr_count;
    do_start(2);
    run_load(2, 1'b0, 1'b1);
    check("bad_error", {31'd0, error}, 32'd1);
    check("bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("bad_writes", wr_count - base, 32'd2);

    // Stalled stream from ERROR
    base = wr_count;
    do_start(2);
    run_load(2, 1'b1, 1'b0);
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_writes", wr_count - base, 32'd2);

    // Zero and over-capacity lengths
    base = wr_count;
    do_start(0);
    @(negedge sysclk);
    check("zero_error", {31'd0, error}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    do_start(1025);
    repeat (3) @(negedge sysclk);
    check("over_error", {31'd0, error}, 32'd1);
    check("bad_len_writes", wr_count - base, 32'd0);

    // Full capacity
    for (int i = 0; i < 1024; i++) words[i] = $urandom;
    base = wr_count;
    do_start(1024);
    run_load(1024, 1'b0, 1'b0);
    check("cap_done", {31'd0, done}, 32'd1);
    check("cap_writes", wr_count - base, 32'd1024);
    check("cap_last_addr", last_addr, 32'h00000FFC);

    // Reset after five bytes
    words[0] = 32'hA5A5F00D;
    do_start(2);
    exp_addr_q.push_back(32'd0);
    exp_data_q.push_back(words[0]);
    for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], 1'b0);
    send_byte(8'h77, 1'b0);
    @(negedge sysclk);
    check("partial_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    rst = 1'b1;
    @(posedge sysclk);
    #1 rst = 1'b0;
    @(negedge sysclk);
    check("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("midrst_flags", {28'd0, busy, done, error, byte_ready}, 32'd0);
    check("midrst_w_en", {28'd0, mem_byte_w_en}, 32'd0);
    check("midrst_addr", {20'd0, mem_wr_addr}, 32'd0);
    check("midrst_data", mem_wr_data, 32'd0);

    check("sb_empty", exp_addr_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
